// File: rtl/cpu_execute_mc.sv
// cpu_execute_mc: moxie execute stage with a single-cycle ALU, CMP flags and
// iterative shift-add multiply / restoring divide behind a busy interlock.
module cpu_execute_mc #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 4,
    parameter int OP_W  = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             valid_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] regA_i,
    input  logic [WIDTH-1:0] regB_i,
    input  logic [WIDTH-1:0] operand_i,
    input  logic [IDX_W-1:0] register_write_index_i,
    output logic             busy_o,
    output logic [IDX_W-1:0] register_write_index_o,
    output logic             register_write_enable_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       flags_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [OP_W-1:0] OP_LDI  = OP_W'(6'h01);
    localparam logic [OP_W-1:0] OP_MOV  = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_CMP  = OP_W'(6'h0e);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'h26);
    localparam logic [OP_W-1:0] OP_LSHR = OP_W'(6'h27);
    localparam logic [OP_W-1:0] OP_ASHL = OP_W'(6'h28);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'h29);
    localparam logic [OP_W-1:0] OP_NEG  = OP_W'(6'h2a);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'h2b);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(6'h2c);
    localparam logic [OP_W-1:0] OP_ASHR = OP_W'(6'h2d);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6'h2e);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(6'h2f);
    localparam logic [OP_W-1:0] OP_DIV  = OP_W'(6'h31);
    localparam logic [OP_W-1:0] OP_UDIV = OP_W'(6'h32);
    localparam logic [OP_W-1:0] OP_MOD  = OP_W'(6'h33);
    localparam logic [OP_W-1:0] OP_UMOD = OP_W'(6'h34);
    localparam logic [OP_W-1:0] OP_INC  = OP_W'(6'h3a);
    localparam logic [OP_W-1:0] OP_DEC  = OP_W'(6'h3b);
    localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d, res_q, res_d;
    logic [IDX_W-1:0] pidx_q, pidx_d, idx_q, idx_d;
    logic             mul_q, mul_d, mod_q, mod_d, qneg_q, qneg_d, rneg_q, rneg_d, we_q, we_d;
    logic [4:0]       flags_q, flags_d, cmp;
    logic [WIDTH-1:0] alu, a_mag, b_mag, s_acc, s_x, s_y, mul_acc, div_acc, div_x, done_val;
    logic [WIDTH:0]   rem_try;
    logic [CW-1:0]    sh;
    logic             single, idle, accept, is_mul, is_sdiv, is_mod, is_div, a_neg, b_neg, ge, last;

    assign sh = regB_i[CW-1:0];
    always_comb begin
        alu = '0;
        single = 1'b1;
        case (op_i)
            OP_ADD:  alu = regA_i + regB_i;
            OP_SUB:  alu = regA_i - regB_i;
            OP_AND:  alu = regA_i & regB_i;
            OP_OR:   alu = regA_i | regB_i;
            OP_XOR:  alu = regA_i ^ regB_i;
            OP_NOT:  alu = ~regB_i;
            OP_NEG:  alu = -regB_i;
            OP_MOV:  alu = regB_i;
            OP_LDI:  alu = operand_i;
            OP_INC:  alu = regA_i + operand_i;
            OP_DEC:  alu = regA_i - operand_i;
            OP_ASHL: alu = regA_i << sh;
            OP_LSHR: alu = regA_i >> sh;
            OP_ASHR: alu = $signed(regA_i) >>> sh;
            default: single = 1'b0;
        endcase
    end

    assign cmp = {regA_i == regB_i, $signed(regA_i) < $signed(regB_i), regA_i < regB_i,
                  $signed(regA_i) > $signed(regB_i), regA_i > regB_i};
    assign idle    = state_q == S_IDLE;
    assign busy_o  = !idle;
    assign accept  = valid_i & ~stall_i & idle;
    assign is_mul  = op_i == OP_MUL;
    assign is_sdiv = op_i == OP_DIV || op_i == OP_MOD;
    assign is_mod  = op_i == OP_MOD || op_i == OP_UMOD;
    assign is_div  = is_sdiv || op_i == OP_UDIV || op_i == OP_UMOD;
    assign a_neg   = is_sdiv & regA_i[WIDTH-1];
    assign b_neg   = is_sdiv & regB_i[WIDTH-1];
    assign a_mag   = a_neg ? -regA_i : regA_i;
    assign b_mag   = b_neg ? -regB_i : regB_i;
    // The accept edge already performs the first iteration, so one step
    // datapath serves both the accept edge (fresh operands) and MUL/DIV states.
    assign s_acc   = idle ? '0 : acc_q;
    assign s_x     = idle ? (is_mul ? regA_i : a_mag) : x_q;
    assign s_y     = idle ? (is_mul ? regB_i : b_mag) : y_q;
    assign mul_acc = s_acc + (s_y[0] ? s_x : '0);
    assign rem_try = {s_acc, s_x[WIDTH-1]};
    assign ge      = rem_try >= {1'b0, s_y};
    assign div_acc = ge ? WIDTH'(rem_try - {1'b0, s_y}) : rem_try[WIDTH-1:0];
    assign div_x   = {s_x[WIDTH-2:0], ge};
    assign last    = cnt_q == CW'(WIDTH - 1);
    assign done_val = mul_q ? acc_q : mod_q ? (rneg_q ? -acc_q : acc_q) : (qneg_q ? -x_q : x_q);

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        x_d = x_q;
        y_d = y_q;
        mul_d = mul_q;
        mod_d = mod_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        pidx_d = pidx_q;
        res_d = res_q;
        idx_d = idx_q;
        we_d = 1'b0;
        flags_d = flags_q;
        if (accept) begin
            if (single) begin
                res_d = alu;
                idx_d = register_write_index_i;
                we_d = 1'b1;
            end
            if (op_i == OP_CMP) flags_d = cmp;
            if (is_mul || is_div) begin
                pidx_d = register_write_index_i;
                mul_d = is_mul;
                mod_d = is_mod;
                qneg_d = a_neg ^ b_neg;
                rneg_d = a_neg;
                cnt_d = CW'(1);
            end
            if (is_mul) begin
                state_d = S_MUL;
                acc_d = mul_acc;
                x_d = s_x << 1;
                y_d = s_y >> 1;
            end else if (is_div && regB_i == '0) begin
                state_d = S_DONE;
                acc_d = regA_i;
                x_d = '1;
                qneg_d = 1'b0;
                rneg_d = 1'b0;
            end else if (is_div) begin
                state_d = S_DIV;
                acc_d = div_acc;
                x_d = div_x;
                y_d = s_y;
            end
        end else if (state_q == S_MUL || state_q == S_DIV) begin
            acc_d = state_q == S_MUL ? mul_acc : div_acc;
            x_d = state_q == S_MUL ? s_x << 1 : div_x;
            y_d = state_q == S_MUL ? s_y >> 1 : s_y;
            cnt_d = cnt_q + 1'b1;
            state_d = last ? S_DONE : state_q;
        end else if (state_q == S_DONE && !stall_i) begin
            res_d = done_val;
            idx_d = pidx_q;
            we_d = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            x_q <= '0;
            y_q <= '0;
            mul_q <= 1'b0;
            mod_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            pidx_q <= '0;
            res_q <= '0;
            idx_q <= '0;
            we_q <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            x_q <= x_d;
            y_q <= y_d;
            mul_q <= mul_d;
            mod_q <= mod_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            pidx_q <= pidx_d;
            res_q <= res_d;
            idx_q <= idx_d;
            we_q <= we_d;
            flags_q <= flags_d;
        end
    end

    assign result_o = res_q;
    assign register_write_index_o = idx_q;
    assign register_write_enable_o = we_q;
    assign flags_o = flags_q;
endmodule
